// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle divide sequencer for the EX stage.
// Runs a radix-2 restoring division over DATA_W steps for DIV/DIVU, reports a
// stall request while the divide is in flight, and returns {remainder, quotient}
// for the HI/LO write path. A flush (annul_i) abandons any operation in progress.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   signed_div_i 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request; held high by EX until ready_o is seen
//   annul_i      flush; aborts the operation in progress
//   result_o     {remainder, quotient}, registered
//   ready_o      result valid, registered
//   busy_o       stall request, decoded from state and the request inputs
module ex_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0]   ZERO_D   = {DATA_W{1'b0}};
  localparam logic [2*DATA_W-1:0] ZERO_2D  = {(2*DATA_W){1'b0}};
  localparam logic [DATA_W-1:0]   ONE_D    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DATA_W);

  // Two's complement negation, modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return (~x) + ONE_D;
  endfunction

  // Magnitude of an operand: only negated for a signed divide with the MSB set.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic            is_signed);
    if (is_signed && x[DATA_W-1]) begin
      return negate(x);
    end else begin
      return x;
    end
  endfunction

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   shreg;     // {partial remainder, quotient/dividend bits}
  logic [DATA_W-1:0]     divisor;   // |b|
  logic                  sign_q;
  logic                  sign_r;

  logic [2*DATA_W-1:0]   shifted;
  logic [DATA_W+1:0]     trial;
  logic                  borrow;
  logic [2*DATA_W-1:0]   step_next;
  logic [DATA_W-1:0]     quo_final;
  logic [DATA_W-1:0]     rem_final;

  // One restoring-division step. The bit shifted out of the remainder is kept
  // as the trial minuend's top bit so divisors above 2^(DATA_W-1) stay exact;
  // the extra guard bit turns the subtraction's sign into the borrow.
  always_comb begin
    shifted   = {shreg[2*DATA_W-2:0], 1'b0};
    trial     = {1'b0, shreg[2*DATA_W-1], shifted[2*DATA_W-1:DATA_W]}
              - {2'b00, divisor};
    borrow    = trial[DATA_W+1];
    if (borrow) begin
      step_next = shifted;
    end else begin
      step_next = {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
    end
  end

  // Sign correction applied when the last step has completed.
  always_comb begin
    if (sign_q) begin
      quo_final = negate(shreg[DATA_W-1:0]);
    end else begin
      quo_final = shreg[DATA_W-1:0];
    end
    if (sign_r) begin
      rem_final = negate(shreg[2*DATA_W-1:DATA_W]);
    end else begin
      rem_final = shreg[2*DATA_W-1:DATA_W];
    end
  end

  // Stall request: covers the accepting cycle in IDLE so the pipeline holds
  // from the request through the cycle the result appears.
  always_comb begin
    busy_o = 1'b0;
    case (state)
      IDLE:    busy_o = start_i & ~annul_i;
      BYZERO:  busy_o = 1'b1;
      BUSY:    busy_o = 1'b1;
      DONE:    busy_o = 1'b0;
      default: busy_o = 1'b0;
    endcase
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= ZERO_C;
      shreg    <= ZERO_2D;
      divisor  <= ZERO_D;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= ZERO_2D;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_o <= ZERO_2D;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == ZERO_D) begin
              state <= BYZERO;
            end else begin
              divisor <= magnitude(opdata2_i, signed_div_i);
              shreg   <= {ZERO_D, magnitude(opdata1_i, signed_div_i)};
              sign_q  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              sign_r  <= signed_div_i & opdata1_i[DATA_W-1];
              cnt     <= ZERO_C;
              state   <= BUSY;
            end
          end else begin
            state <= IDLE;
          end
        end

        BYZERO: begin
          result_o <= ZERO_2D;
          if (annul_i) begin
            ready_o <= 1'b0;
            state   <= IDLE;
          end else begin
            ready_o <= 1'b1;
            state   <= DONE;
          end
        end

        BUSY: begin
          // A flush wins over both the step and the finalize edge.
          if (annul_i) begin
            result_o <= ZERO_2D;
            ready_o  <= 1'b0;
            state    <= IDLE;
          end else if (cnt == LAST_CNT) begin
            result_o <= {rem_final, quo_final};
            ready_o  <= 1'b1;
            state    <= DONE;
          end else begin
            shreg <= step_next;
            cnt   <= cnt + ONE_C;
          end
        end

        DONE: begin
          if (annul_i || !start_i) begin
            result_o <= ZERO_2D;
            ready_o  <= 1'b0;
            state    <= IDLE;
          end else begin
            ready_o <= 1'b1;
          end
        end

        default: begin
          result_o <= ZERO_2D;
          ready_o  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed cases plus random operands
// compared against an arithmetic reference of signed/unsigned division.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient}; C-style truncating division, zero divisor gives 0.
  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sd) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Runs one request from IDLE with start held; scrambles operands while waiting.
  // Returns the result, the edge count after E0 at which ready appeared (0 on
  // timeout) and whether busy_o followed the expected profile.
  task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat = 0;
    signed_div_i = sd; opdata1_i = a; opdata2_i = b;
    start_i = 1'b1; annul_i = 1'b0;
    #1;
    if (busy_o !== 1'b1) busy_ok = 1'b0;
    @(posedge clk); #1;            // E0
    for (int k = 1; k <= 40; k++) begin
      opdata1_i = $urandom; opdata2_i = $urandom;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (busy_o !== 1'b0) busy_ok = 1'b0;
    res = result_o;
  endtask

  task automatic drop_start;
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b result=%h busy=%b, required 0/0/0", ready_o, result_o, busy_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    logic [31:0] a_tab [4] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    logic [31:0] b_tab [4] = '{32'd7, 32'h10, 32'h80000001, 32'd9};
    logic [63:0] res, exp_v;
    int lat;
    bit bok;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      if (i < 4) begin
        a = a_tab[i]; b = b_tab[i];
      end else begin
        a = $urandom;
        b = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : ($urandom | 32'd1);
      end
      exp_v = ref_div(1'b0, a, b);
      run_op(1'b0, a, b, res, lat, bok);
      total++;
      if (res !== exp_v) begin
        bad++;
        $display("FAIL divu %h/%h: got %h, required %h", a, b, res, exp_v);
      end
      total++;
      if (lat != 33 || !bok) begin
        bad++;
        $display("FAIL divu_timing %h/%h: latency %0d busy_ok %0d, required 33 1", a, b, lat, bok);
      end
      drop_start();
      total++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        bad++;
        $display("FAIL divu_release: ready=%b result=%h, required 0/0", ready_o, result_o);
      end
    end
  endtask

  task automatic test_signed;
    logic [31:0] a_tab [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000};
    logic [31:0] b_tab [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
    logic [63:0] res, exp_v;
    int lat;
    bit bok;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      if (i < 4) begin
        a = a_tab[i]; b = b_tab[i];
      end else begin
        a = $urandom;
        b = (i % 2 == 0) ? (32'($urandom_range(1, 300)) ^ {32{a[0]}}) : $urandom;
        if (b == 32'd0) b = 32'd1;
      end
      exp_v = ref_div(1'b1, a, b);
      run_op(1'b1, a, b, res, lat, bok);
      total++;
      if (res !== exp_v || lat != 33 || !bok) begin
        bad++;
        $display("FAIL div %h/%h: got %h lat %0d busy_ok %0d, required %h lat 33 busy_ok 1",
                 a, b, res, lat, bok, exp_v);
      end
      drop_start();
    end
  endtask

  task automatic test_byzero;
    logic [63:0] res;
    int lat;
    bit bok;
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 32'h12345678, 32'd0, res, lat, bok);
      total++;
      if (res !== 64'd0 || lat != 1 || !bok) begin
        bad++;
        $display("FAIL byzero s=%0d: result %h lat %0d busy_ok %0d, required 0 lat 1 busy_ok 1",
                 s, res, lat, bok);
      end
      drop_start();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL byzero_release: ready=%b, required 0", ready_o);
      end
    end
  endtask

  task automatic test_annul;
    logic [63:0] res;
    int lat;
    bit bok;
    // Flush during BUSY on E10.
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1;
    start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk); #1;            // E0
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;            // E10
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL annul_busy: ready=%b result=%h busy=%b, required 0/0/0", ready_o, result_o, busy_o);
    end
    // Request with flush held stays idle.
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL annul_idle: ready=%b busy=%b, required 0/0", ready_o, busy_o);
    end
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd9, 32'd3, res, lat, bok);
    total++;
    if (res !== {32'd0, 32'd3} || lat != 33 || !bok) begin
      bad++;
      $display("FAIL annul_recover: result %h lat %0d busy_ok %0d, required %h lat 33 busy_ok 1",
               res, lat, bok, {32'd0, 32'd3});
    end
    // Flush while DONE with start still high clears the result.
    annul_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_done: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] res, exp_v;
    int lat;
    bit bok;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk); #1;            // E0
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;            // E15
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b result=%h busy=%b, required 0/0/0", ready_o, result_o, busy_o);
    end
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_quiet: ready=%b busy=%b, required 0/0", ready_o, busy_o);
    end
    exp_v = ref_div(1'b1, 32'hFFFFFC18, 32'd7);
    run_op(1'b1, 32'hFFFFFC18, 32'd7, res, lat, bok);
    total++;
    if (res !== exp_v || lat != 33) begin
      bad++;
      $display("FAIL reset_mid_after: result %h lat %0d, required %h lat 33", res, lat, exp_v);
    end
    drop_start();
  endtask

  task automatic test_done_hold;
    logic [63:0] res, exp_v;
    int lat;
    bit bok;
    int stable_bad;
    exp_v = ref_div(1'b0, 32'd123456789, 32'd1000);
    run_op(1'b0, 32'd123456789, 32'd1000, res, lat, bok);
    stable_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== exp_v || busy_o !== 1'b0) stable_bad++;
    end
    total++;
    if (res !== exp_v || stable_bad != 0) begin
      bad++;
      $display("FAIL done_hold: result %h, %0d unstable cycles, required %h and 0", res, stable_bad, exp_v);
    end
    drop_start();
  endtask

  task automatic test_back_to_back;
    logic [63:0] res, exp_v;
    int lat;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      bit sd;
      a = $urandom; b = $urandom_range(1, 65535); sd = i[0];
      exp_v = ref_div(sd, a, b);
      run_op(sd, a, b, res, lat, bok);
      total++;
      if (res !== exp_v || lat != 33 || !bok) begin
        bad++;
        $display("FAIL back_to_back %0d %h/%h: got %h lat %0d, required %h lat 33", i, a, b, res, lat, exp_v);
      end
      drop_start();                // single IDLE cycle before the next request
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_reset_mid();
    test_done_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
